// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for a full cyc,
// and a watchdog that aborts a strobe the slave never acknowledges.
module wb_arbiter_2m #(
  parameter int ADDR_W  = 36,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_W-1:0]     m0_adr_i,
  input  logic [DATA_W/8-1:0]   m0_sel_i,
  input  logic [DATA_W-1:0]     m0_dat_i,
  output logic [DATA_W-1:0]     m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_W-1:0]     m1_adr_i,
  input  logic [DATA_W/8-1:0]   m1_sel_i,
  input  logic [DATA_W-1:0]     m1_dat_i,
  output logic [DATA_W-1:0]     m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_W-1:0]     s_adr_o,
  output logic [DATA_W/8-1:0]   s_sel_o,
  output logic [DATA_W-1:0]     s_dat_o,
  input  logic [DATA_W-1:0]     s_dat_i,
  input  logic                  s_ack_i,

  output logic [1:0]            gnt_o,
  output logic [3:0]            dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_GNT0  = 4'b0010,
    S_GNT1  = 4'b0100,
    S_ABORT = 4'b1000
  } state_t;

  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);
  localparam bit          WD_EN  = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wd_hit;
  logic        granted;

  // The unacked strobe in progress this cycle is the one that brings the count to TIMEOUT.
  assign wd_hit = WD_EN && (({1'b0, cnt_q} + 17'd1) >= {1'b0, TO_VAL});

  // Read data is broadcast ungated; ack qualifies it.
  assign m0_dat_o    = s_dat_i;
  assign m1_dat_o    = s_dat_i;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    granted  = 1'b0;
    gnt_o    = 2'b00;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_q) begin
            state_d = S_GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = S_GNT1;
            last_d  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d = S_GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = S_GNT1;
          last_d  = 1'b1;
        end
      end

      S_GNT0: begin
        granted  = 1'b1;
        gnt_o    = 2'b01;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        if (!m0_cyc_i) begin
          state_d = S_IDLE;
        end else if (m0_stb_i && !s_ack_i && wd_hit) begin
          m0_err_o = 1'b1;
          state_d  = S_ABORT;
        end
      end

      S_GNT1: begin
        granted  = 1'b1;
        gnt_o    = 2'b10;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        if (!m1_cyc_i) begin
          state_d = S_IDLE;
        end else if (m1_stb_i && !s_ack_i && wd_hit) begin
          m1_err_o = 1'b1;
          state_d  = S_ABORT;
        end
      end

      S_ABORT: begin
        // last_q still names the aborted master; wait for it to let go.
        if (!(last_q ? m1_cyc_i : m0_cyc_i)) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (!granted || state_d != state_q || !s_stb_o || s_ack_i) begin
      cnt_d = '0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_o));
  a_state_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(state_q));
  a_err_exclusive: assert property (@(posedge clk) disable iff (rst)
                                    !(m0_err_o && m1_err_o));

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: cycle-by-cycle vector table with hand-derived expectations,
// followed by a short randomized data-path sequence on a held grant.
module tb_wb_arbiter_2m;

  localparam int ADDR_W = 36;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_W-1:0] m0_adr_i;
  logic [SEL_W-1:0]  m0_sel_i;
  logic [DATA_W-1:0] m0_dat_i, m0_dat_o;
  logic              m0_ack_o, m0_err_o;
  logic              m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_W-1:0] m1_adr_i;
  logic [SEL_W-1:0]  m1_sel_i;
  logic [DATA_W-1:0] m1_dat_i, m1_dat_o;
  logic              m1_ack_o, m1_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_W-1:0] s_adr_o;
  logic [SEL_W-1:0]  s_sel_o;
  logic [DATA_W-1:0] s_dat_o, s_dat_i;
  logic              s_ack_i;
  logic [1:0]        gnt_o;
  logic [3:0]        dbg_state_o;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  wb_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- vector table ----------------
  // exp packing: {gnt[1:0], s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}
  typedef struct {
    logic       rst, c0, s0, c1, s1, ack;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  task automatic v(input logic r, input logic c0, input logic s0, input logic c1,
                   input logic s1, input logic ack, input logic [7:0] e);
    vec_t t;
    t.rst = r; t.c0 = c0; t.s0 = s0; t.c1 = c1; t.s1 = s1; t.ack = ack; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    rst = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b1;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    m0_adr_i = 36'h1_0000_0040; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
    m1_adr_i = 36'h0_2000_0100; m1_dat_i = 32'h1234_5678; m1_sel_i = 4'h3;
    s_ack_i  = 1'b0;
    s_dat_i  = '0;
  endtask

  task automatic apply(input vec_t t);
    rst      = t.rst;
    m0_cyc_i = t.c0; m0_stb_i = t.s0;
    m1_cyc_i = t.c1; m1_stb_i = t.s1;
    s_ack_i  = t.ack;
    s_dat_i  = $urandom;
    exp_q.push_back(t.exp);
  endtask

  // ---------------- scoreboard ----------------
  task automatic score(input int idx);
    logic [7:0]        e;
    logic [7:0]        act;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic [SEL_W-1:0]  es;
    logic              ew;
    string             tag;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 64'd0, 64'd1);
      return;
    end
    e   = exp_q.pop_front();
    act = {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
    tag = $sformatf("vec%0d_ctrl", idx);
    check(tag, 64'(act), 64'(e));
    case (e[7:6])
      2'b01:   begin ea = 36'h1_0000_0040; ed = 32'hDEADBEEF;  es = 4'hF; ew = 1'b1; end
      2'b10:   begin ea = 36'h0_2000_0100; ed = 32'h1234_5678; es = 4'h3; ew = 1'b0; end
      default: begin ea = '0;              ed = '0;            es = '0;   ew = 1'b0; end
    endcase
    check($sformatf("vec%0d_adr", idx), 64'(s_adr_o), 64'(ea));
    check($sformatf("vec%0d_dat", idx), 64'(s_dat_o), 64'(ed));
    check($sformatf("vec%0d_sel_we", idx), 64'({s_sel_o, s_we_o}), 64'({es, ew}));
    check($sformatf("vec%0d_rdat", idx), 64'({m0_dat_o, m1_dat_o}), 64'({s_dat_i, s_dat_i}));
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd, rs;
    logic [SEL_W-1:0]  rsel;

    // reset / single write with 2-cycle ack latency
    v(1,0,0,0,0,0, 8'b00_00_0000);
    v(0,1,1,0,0,0, 8'b00_00_0000);
    v(0,1,1,0,0,0, 8'b01_11_0000);
    v(0,1,1,0,0,0, 8'b01_11_0000);
    v(0,1,1,0,0,1, 8'b01_11_1000);
    v(0,0,0,0,0,0, 8'b01_00_0000);
    v(0,0,0,0,0,0, 8'b00_00_0000);
    // simultaneous requests after reset: m0 first, then m1
    v(1,0,0,0,0,0, 8'b00_00_0000);
    v(0,1,1,1,1,0, 8'b00_00_0000);
    v(0,1,1,1,1,1, 8'b01_11_1000);
    v(0,0,0,1,1,0, 8'b01_00_0000);
    v(0,0,0,1,1,0, 8'b00_00_0000);
    v(0,0,0,1,1,1, 8'b10_11_0010);
    v(0,0,0,0,0,0, 8'b10_00_0000);
    v(0,0,0,0,0,0, 8'b00_00_0000);
    // second simultaneous request: m0 again since m1 was last
    v(0,1,1,1,1,0, 8'b00_00_0000);
    v(0,1,1,1,1,1, 8'b01_11_1000);
    v(0,0,0,1,1,0, 8'b01_00_0000);
    v(0,1,1,1,1,0, 8'b00_00_0000);
    // m1 burst of 3 reads while m0 waits
    v(0,1,1,1,1,1, 8'b10_11_0010);
    v(0,1,1,1,1,0, 8'b10_11_0000);
    v(0,1,1,1,1,1, 8'b10_11_0010);
    v(0,1,1,1,0,0, 8'b10_10_0000);
    v(0,1,1,1,1,1, 8'b10_11_0010);
    v(0,1,1,0,0,0, 8'b10_00_0000);
    v(0,1,1,0,0,0, 8'b00_00_0000);
    v(0,1,1,0,0,1, 8'b01_11_1000);
    v(0,0,0,0,0,0, 8'b01_00_0000);
    v(0,0,0,0,0,0, 8'b00_00_0000);
    // watchdog abort on m0, m1 waiting
    v(0,1,1,0,0,0, 8'b00_00_0000);
    for (int i = 0; i < 7; i++) v(0,1,1,1,1,0, 8'b01_11_0000);
    v(0,1,1,1,1,0, 8'b01_11_0100);
    v(0,1,1,1,1,0, 8'b00_00_0000);
    v(0,0,0,1,1,0, 8'b00_00_0000);
    v(0,0,0,1,1,0, 8'b00_00_0000);
    v(0,0,0,1,1,1, 8'b10_11_0010);
    v(0,0,0,0,0,0, 8'b10_00_0000);
    v(0,0,0,0,0,0, 8'b00_00_0000);
    // ack on the cycle the count would reach the limit
    v(0,1,1,0,0,0, 8'b00_00_0000);
    for (int i = 0; i < 7; i++) v(0,1,1,0,0,0, 8'b01_11_0000);
    v(0,1,1,0,0,1, 8'b01_11_1000);
    v(0,1,1,0,0,0, 8'b01_11_0000);
    v(0,0,0,0,0,0, 8'b01_00_0000);
    v(0,0,0,0,0,0, 8'b00_00_0000);
    // reset while m1 granted with stb and ack pending
    v(0,0,0,1,1,0, 8'b00_00_0000);
    v(0,0,0,1,1,0, 8'b10_11_0000);
    v(1,0,0,1,1,1, 8'b10_11_0010);
    v(0,0,0,1,1,1, 8'b00_00_0000);
    v(0,0,0,1,1,0, 8'b10_11_0000);
    v(0,0,0,0,0,0, 8'b10_00_0000);
    v(0,0,0,0,0,0, 8'b00_00_0000);

    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 apply(vecs[i]);
      @(negedge clk);
      score(i);
    end

    // hand-written: random data through a held m0 grant, then cyc drop mid-stb
    @(posedge clk);
    #1 drive_idle(); rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      ra   = {4'(i), 32'($urandom)};
      rd   = $urandom;
      rs   = $urandom;
      rsel = 4'($urandom_range(0, 15));
      m0_adr_i = ra; m0_dat_i = rd; m0_sel_i = rsel; s_dat_i = rs;
      s_ack_i  = (i % 2 == 1);
      @(negedge clk);
      check("rnd_adr", 64'(s_adr_o), 64'(ra));
      check("rnd_dat", 64'(s_dat_o), 64'(rd));
      check("rnd_sel", 64'(s_sel_o), 64'(rsel));
      check("rnd_rdat", 64'(m0_dat_o), 64'(rs));
      check("rnd_ack", 64'({m0_ack_o, m1_ack_o, gnt_o}), 64'({(i % 2 == 1), 1'b0, 2'b01}));
    end
    @(posedge clk);
    #1 m0_cyc_i = 1'b0; s_ack_i = 1'b0;
    @(negedge clk);
    check("drop_cyc_mid_stb", 64'({gnt_o, s_cyc_o, s_stb_o}), 64'({2'b01, 1'b0, 1'b1}));
    @(posedge clk);
    #1 m0_stb_i = 1'b0;
    @(negedge clk);
    check("drop_cyc_idle", 64'({gnt_o, s_cyc_o}), 64'({2'b00, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
